// File: rtl/int_divider.sv
// Fixed-latency (18 edges), fully pipelined 32-bit signed divider.
// Restoring division on magnitudes, two quotient bits per stage, signs applied at the end.
module int_divider (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        s_axis_dividend_tvalid,
   input  logic [31:0] s_axis_dividend_tdata,
   input  logic        s_axis_divisor_tvalid,
   input  logic [31:0] s_axis_divisor_tdata,
   output logic        m_axis_dout_tvalid,
   output logic [63:0] m_axis_dout_tdata
);

   // Per-stage state: partial remainder, dividend bits still to consume with
   // quotient bits shifted in from the bottom, divisor magnitude and flags.
   logic [32:0] rem_q   [0:16];
   logic [31:0] quo_q   [0:16];
   logic [31:0] dvs_q   [0:16];
   logic        vld_q   [0:16];
   logic        neg_q_q [0:16];
   logic        neg_r_q [0:16];
   logic        dz_q    [0:16];
   logic        ovf_q   [0:16];

   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] q_fix;
   logic [31:0] r_fix;
   logic [63:0] fin_d;
   logic        fin_v;

   function automatic logic [64:0] div_step2(input logic [32:0] r_in,
                                             input logic [31:0] q_in,
                                             input logic [31:0] d);
      logic [32:0] r;
      logic [31:0] q;
      logic [32:0] t;
      r = r_in;
      q = q_in;
      for (int unsigned i = 0; i < 2; i++) begin
         r = {r[31:0], q[31]};
         q = {q[30:0], 1'b0};
         t = r - {1'b0, d};
         if (!t[32]) begin
            r    = t;
            q[0] = 1'b1;
         end
      end
      return {r, q};
   endfunction

   // 0x80000000 maps to unsigned 2^31, which still fits the 32-bit magnitude.
   always_comb begin
      a_mag = s_axis_dividend_tdata[31] ? (~s_axis_dividend_tdata + 32'd1) : s_axis_dividend_tdata;
      b_mag = s_axis_divisor_tdata[31]  ? (~s_axis_divisor_tdata + 32'd1)  : s_axis_divisor_tdata;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int unsigned k = 0; k <= 16; k++) begin
            rem_q[k]   <= '0;
            quo_q[k]   <= '0;
            dvs_q[k]   <= '0;
            vld_q[k]   <= 1'b0;
            neg_q_q[k] <= 1'b0;
            neg_r_q[k] <= 1'b0;
            dz_q[k]    <= 1'b0;
            ovf_q[k]   <= 1'b0;
         end
      end else begin
         vld_q[0]   <= s_axis_dividend_tvalid && s_axis_divisor_tvalid;
         rem_q[0]   <= '0;
         quo_q[0]   <= a_mag;
         dvs_q[0]   <= b_mag;
         neg_q_q[0] <= s_axis_dividend_tdata[31] ^ s_axis_divisor_tdata[31];
         neg_r_q[0] <= s_axis_dividend_tdata[31];
         dz_q[0]    <= (s_axis_divisor_tdata == '0);
         ovf_q[0]   <= (s_axis_dividend_tdata == 32'h8000_0000) && (s_axis_divisor_tdata == '1);
         for (int unsigned k = 1; k <= 16; k++) begin
            {rem_q[k], quo_q[k]} <= div_step2(rem_q[k-1], quo_q[k-1], dvs_q[k-1]);
            dvs_q[k]   <= dvs_q[k-1];
            vld_q[k]   <= vld_q[k-1];
            neg_q_q[k] <= neg_q_q[k-1];
            neg_r_q[k] <= neg_r_q[k-1];
            dz_q[k]    <= dz_q[k-1];
            ovf_q[k]   <= ovf_q[k-1];
         end
      end
   end

   // Divide by zero leaves remainder magnitude = |dividend|, so re-signing it
   // restores the dividend exactly; only the quotient needs overriding.
   always_comb begin
      q_fix = neg_q_q[16] ? (~quo_q[16] + 32'd1) : quo_q[16];
      r_fix = neg_r_q[16] ? (~rem_q[16][31:0] + 32'd1) : rem_q[16][31:0];
      if (dz_q[16]) begin
         q_fix = '1;
      end
      if (ovf_q[16]) begin
         q_fix = 32'h8000_0000;
         r_fix = '0;
      end
   end

   // Sign-fixup register followed by the output register gives the 18-edge latency.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         fin_v              <= 1'b0;
         fin_d              <= '0;
         m_axis_dout_tvalid <= 1'b0;
         m_axis_dout_tdata  <= '0;
      end else begin
         fin_v              <= vld_q[16];
         fin_d              <= {q_fix, r_fix};
         m_axis_dout_tvalid <= fin_v;
         if (fin_v) begin
            m_axis_dout_tdata <= fin_d;
         end
      end
   end

endmodule

// File: tb/tb_int_divider.sv
// Self-checking bench for int_divider: directed and random operations against
// a plain-arithmetic reference with a queue of timed expected results.
module tb_int_divider;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        a_v;
   logic [31:0] a_d;
   logic        b_v;
   logic [31:0] b_d;
   logic        o_v;
   logic [63:0] o_d;

   int_divider dut (
      .aclk                   (aclk),
      .aresetn                (aresetn),
      .s_axis_dividend_tvalid (a_v),
      .s_axis_dividend_tdata  (a_d),
      .s_axis_divisor_tvalid  (b_v),
      .s_axis_divisor_tdata   (b_d),
      .m_axis_dout_tvalid     (o_v),
      .m_axis_dout_tdata      (o_d)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      int          due;
      logic [63:0] data;
   } exp_t;

   exp_t        exp_q[$];
   int          cyc    = 0;
   logic [63:0] last_d = '0;
   int          n_err  = 0;
   int          n_chk  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      int sa;
      int sb;
      if (b == 32'd0) return {32'hFFFF_FFFF, a};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
      sa = a;
      sb = b;
      return {32'(sa / sb), 32'(sa % sb)};
   endfunction

   // One clock: record acceptance, then check outputs 1 time unit after the edge.
   task automatic tick(input logic [63:0] e);
      logic acc;
      exp_t it;
      acc = a_v && b_v && aresetn;
      @(posedge aclk);
      cyc++;
      if (acc) begin
         it.due  = cyc + 18;
         it.data = e;
         exp_q.push_back(it);
      end
      #1;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         chk("tvalid_pulse", 64'(o_v), 64'd1);
         chk("tdata", o_d, exp_q[0].data);
         last_d = exp_q[0].data;
         void'(exp_q.pop_front());
      end else begin
         chk("tvalid_idle", 64'(o_v), 64'd0);
         chk("tdata_hold", o_d, last_d);
      end
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [63:0] e);
      a_v = 1'b1;
      b_v = 1'b1;
      a_d = a;
      b_d = b;
      tick(e);
   endtask

   task automatic idle(input int n);
      a_v = 1'b0;
      b_v = 1'b0;
      for (int i = 0; i < n; i++) tick('0);
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      aresetn = 1'b0;
      a_v = 1'b0;
      b_v = 1'b0;
      a_d = '0;
      b_d = '0;
      #2;
      chk("reset_tvalid", 64'(o_v), 64'd0);
      chk("reset_tdata", o_d, 64'd0);
      idle(2);
      aresetn = 1'b1;
      idle(1);

      // Basic single op with hold afterwards
      issue(32'd100, 32'd7, {32'h0000_000E, 32'h0000_0002});
      idle(25);

      // Signs and special cases, back to back
      issue(-32'sd100, 32'd7,       {32'hFFFF_FFF2, 32'hFFFF_FFFE});
      issue(32'd100,   -32'sd7,     {32'hFFFF_FFF2, 32'h0000_0002});
      issue(-32'sd100, -32'sd7,     {32'h0000_000E, 32'hFFFF_FFFE});
      issue(32'd5,     32'd0,       {32'hFFFF_FFFF, 32'h0000_0005});
      issue(32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0000_0000});
      issue(32'd0,     32'd9,       {32'h0000_0000, 32'h0000_0000});
      issue(32'h8000_0000, 32'd0,   {32'hFFFF_FFFF, 32'h8000_0000});
      issue(32'h8000_0000, 32'd1,   {32'h8000_0000, 32'h0000_0000});
      issue(32'h7FFF_FFFF, 32'h8000_0000, {32'h0000_0000, 32'h7FFF_FFFF});
      idle(22);

      // Random back-to-back throughput
      for (int i = 0; i < 20; i++) begin
         ra = $urandom;
         case (i % 4)
            0:       rb = $urandom;
            1:       rb = 32'($urandom_range(0, 31)) - 32'd16;
            2:       rb = $urandom >> $urandom_range(0, 31);
            default: rb = 32'($urandom_range(1, 1000));
         endcase
         if (i == 7) rb = 32'd0;
         issue(ra, rb, ref_div(ra, rb));
      end
      idle(22);

      // Held valid with constant operands
      for (int i = 0; i < 30; i++) issue(32'd1000, 32'd3, {32'h0000_014D, 32'h0000_0001});
      idle(22);

      // Lone valid on either side must never be accepted
      a_v = 1'b1; b_v = 1'b0; a_d = 32'd77; b_d = 32'd3;
      for (int i = 0; i < 5; i++) tick('0);
      a_v = 1'b0; b_v = 1'b1;
      for (int i = 0; i < 5; i++) tick('0);
      idle(22);

      // Mid-flight reset discards in-flight work and clears outputs at once
      issue(32'd100, 32'd7, {32'h0000_000E, 32'h0000_0002});
      idle(22);
      issue(32'd1000, 32'd3, {32'h0000_014D, 32'h0000_0001});
      issue(32'd50, 32'd6, {32'h0000_0008, 32'h0000_0002});
      idle(5);
      aresetn = 1'b0;
      #1;
      chk("async_rst_tvalid", 64'(o_v), 64'd0);
      chk("async_rst_tdata", o_d, 64'd0);
      exp_q.delete();
      last_d = '0;
      idle(2);
      aresetn = 1'b1;
      idle(25);

      // Pipeline works again after reset
      issue(32'd1000, 32'd3, {32'h0000_014D, 32'h0000_0001});
      idle(22);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
